// File: rtl/t03_alu_ctrl_decode_if.sv
// Decode-stage bus: fetch-side valid/ready transfer in, decoded ALU controls out.
// master = the decode stage, slave = the surrounding fetch/execute pipeline.
interface t03_alu_ctrl_decode_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc_in;

  logic            out_valid;
  logic            out_ready;
  logic [3:0]      alu_control;
  logic            alu_src;
  logic            auipc;
  logic            lui;
  logic [XLEN-1:0] immediate;
  logic [XLEN-1:0] pc_out;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic            reg_write;
  logic            is_branch;
  logic            illegal;

  modport master (
    input  in_valid, instr, pc_in, out_ready,
    output in_ready, out_valid, alu_control, alu_src, auipc, lui,
           immediate, pc_out, rs1, rs2, rd, reg_write, is_branch, illegal
  );

  modport slave (
    output in_valid, instr, pc_in, out_ready,
    input  in_ready, out_valid, alu_control, alu_src, auipc, lui,
           immediate, pc_out, rs1, rs2, rd, reg_write, is_branch, illegal
  );
endinterface

// File: rtl/t03_alu_ctrl_decode.sv
// RV32I decode-to-execute stage: decodes one instruction into ALU operation and
// operand-select controls, held in a single-entry registered slot with backpressure.
module t03_alu_ctrl_decode #(
  parameter int unsigned XLEN = 32
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   flush,
  t03_alu_ctrl_decode_if.master  bus
);

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LOAD   = 7'b0000011,
    OPC_JALR   = 7'b1100111,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_op_e;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [31:0] ins;
  opcode_e     opc;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  assign ins    = bus.instr;
  assign opc    = opcode_e'(ins[6:0]);
  assign funct3 = ins[14:12];
  assign funct7 = ins[31:25];

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_shamt;

  assign imm_i     = {{20{ins[31]}}, ins[31:20]};
  assign imm_s     = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b     = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u     = {ins[31:12], 12'b0};
  assign imm_j     = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  assign imm_shamt = {27'b0, ins[24:20]};

  logic [3:0]  d_alu;
  logic        d_src;
  logic        d_auipc;
  logic        d_lui;
  logic [31:0] d_imm;
  logic        d_write;
  logic        d_branch;
  logic        d_illegal;

  // Any illegal encoding also suppresses reg_write so a trapped instruction never writes rd.
  always_comb begin
    d_alu     = ALU_ADD;
    d_src     = 1'b0;
    d_auipc   = 1'b0;
    d_lui     = 1'b0;
    d_imm     = '0;
    d_write   = 1'b0;
    d_branch  = 1'b0;
    d_illegal = 1'b0;
    case (opc)
      OPC_OP: begin
        d_alu   = {funct7[5], funct3};
        d_write = 1'b1;
        if (!(funct7 == F7_BASE ||
              (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)))) begin
          d_illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        d_alu   = {1'b0, funct3};
        d_src   = 1'b1;
        d_write = 1'b1;
        d_imm   = imm_i;
        if (funct3 == 3'b001) begin
          d_imm = imm_shamt;
          if (funct7 != F7_BASE) d_illegal = 1'b1;
        end else if (funct3 == 3'b101) begin
          d_imm = imm_shamt;
          if (funct7 == F7_ALT) d_alu = ALU_SRA;
          else if (funct7 != F7_BASE) d_illegal = 1'b1;
        end
      end
      OPC_LOAD, OPC_JALR: begin
        d_src   = 1'b1;
        d_imm   = imm_i;
        d_write = 1'b1;
      end
      OPC_STORE: begin
        d_src = 1'b1;
        d_imm = imm_s;
      end
      OPC_BRANCH: begin
        d_branch = 1'b1;
        d_imm    = imm_b;
        case (funct3[2:1])
          2'b00:   d_alu = ALU_SUB;
          2'b10:   d_alu = ALU_SLT;
          2'b11:   d_alu = ALU_SLTU;
          default: d_illegal = 1'b1;
        endcase
      end
      OPC_LUI: begin
        d_lui   = 1'b1;
        d_src   = 1'b1;
        d_imm   = imm_u;
        d_write = 1'b1;
      end
      OPC_AUIPC: begin
        d_auipc = 1'b1;
        d_src   = 1'b1;
        d_imm   = imm_u;
        d_write = 1'b1;
      end
      OPC_JAL: begin
        d_auipc = 1'b1;
        d_src   = 1'b1;
        d_imm   = imm_j;
        d_write = 1'b1;
      end
      default: d_illegal = 1'b1;
    endcase
    if (d_illegal) d_write = 1'b0;
  end

  logic            valid_q;
  logic [3:0]      alu_q;
  logic            src_q;
  logic            auipc_q;
  logic            lui_q;
  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] pc_q;
  logic [4:0]      rs1_q, rs2_q, rd_q;
  logic            write_q;
  logic            branch_q;
  logic            illegal_q;
  logic            ready;
  logic            capture;

  assign ready   = !valid_q || bus.out_ready;
  assign capture = bus.in_valid && ready && !flush;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      valid_q   <= 1'b0;
      alu_q     <= '0;
      src_q     <= 1'b0;
      auipc_q   <= 1'b0;
      lui_q     <= 1'b0;
      imm_q     <= '0;
      pc_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      write_q   <= 1'b0;
      branch_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q   <= 1'b1;
      alu_q     <= d_alu;
      src_q     <= d_src;
      auipc_q   <= d_auipc;
      lui_q     <= d_lui;
      imm_q     <= d_imm;
      pc_q      <= bus.pc_in;
      rs1_q     <= ins[19:15];
      rs2_q     <= ins[24:20];
      rd_q      <= ins[11:7];
      write_q   <= d_write;
      branch_q  <= d_branch;
      illegal_q <= d_illegal;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.in_ready    = ready;
  assign bus.out_valid   = valid_q;
  assign bus.alu_control = alu_q;
  assign bus.alu_src     = src_q;
  assign bus.auipc       = auipc_q;
  assign bus.lui         = lui_q;
  assign bus.immediate   = imm_q;
  assign bus.pc_out      = pc_q;
  assign bus.rs1         = rs1_q;
  assign bus.rs2         = rs2_q;
  assign bus.rd          = rd_q;
  assign bus.reg_write   = write_q;
  assign bus.is_branch   = branch_q;
  assign bus.illegal     = illegal_q;

endmodule
